// File: rtl/uart_rx_fifo_if.sv
// Bundle of uart_rx_fifo's serial input, FIFO read port and status flags.
// parity_error is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_fifo_if #(
  parameter int CNT_W = 5
);
  logic             rx_serial_data;
  logic             rd_en;
  logic [7:0]       data_out;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] data_count;
  logic             frame_error;
  logic             overflow_error;
`ifdef UART_RX_PARITY_EN
  logic             parity_error;
`endif

  modport master (
    output rx_serial_data, rd_en,
`ifdef UART_RX_PARITY_EN
    input  parity_error,
`endif
    input  data_out, empty, full, data_count, frame_error, overflow_error
  );

  modport slave (
    input  rx_serial_data, rd_en,
`ifdef UART_RX_PARITY_EN
    output parity_error,
`endif
    output data_out, empty, full, data_count, frame_error, overflow_error
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver (8N1) feeding a synchronous byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_error pulse.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic          clk_in,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV    = CLK_FREQ / (BAUD * 16);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_sample_cnt;
  logic [3:0]        w_sample_cnt_next;
  logic [2:0]        r_bit_cnt;
  logic [2:0]        w_bit_cnt_next;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_next;
  logic              r_wr_pend;
  logic              w_wr_pend_next;
  logic              r_frame_err;
  logic              w_frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic              r_par_err;
  logic              w_par_err_next;
  logic              r_par_bad;
  logic              w_par_bad_next;
`endif

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              r_empty;
  logic              r_full;
  logic              r_ovf;
  logic [7:0]        r_data_out;
  logic              w_do_rd;
  logic              w_do_wr;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx_serial_data;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_W'(DIV - 1));

  always_ff @(posedge clk_in) begin
    if (rst || w_tick) r_tick_cnt <= '0;
    else               r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_wr_pend    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err    <= 1'b0;
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_sample_cnt <= w_sample_cnt_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_wr_pend    <= w_wr_pend_next;
      r_frame_err  <= w_frame_err_next;
`ifdef UART_RX_PARITY_EN
      r_par_err    <= w_par_err_next;
      r_par_bad    <= w_par_bad_next;
`endif
    end
  end

  // Each bit window is 16 ticks; data, parity and stop are sampled at count 15.
  always_comb begin
    w_state_next      = r_state;
    w_sample_cnt_next = r_sample_cnt;
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_wr_pend_next    = 1'b0;
    w_frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_next    = 1'b0;
    w_par_bad_next    = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_state_next      = S_START;
          w_sample_cnt_next = '0;
          w_bit_cnt_next    = '0;
`ifdef UART_RX_PARITY_EN
          w_par_bad_next    = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_sample_cnt == 4'd7) begin
            w_sample_cnt_next = '0;
            w_state_next      = r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            w_sample_cnt_next = r_sample_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_sample_cnt_next = r_sample_cnt + 4'd1;
          if (r_sample_cnt == 4'd15) begin
            w_shift_next   = {r_rx_sync, r_shift[7:1]};
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = S_PARITY;
`else
              w_state_next = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_sample_cnt_next = r_sample_cnt + 4'd1;
          if (r_sample_cnt == 4'd15) begin
            w_par_bad_next = ^{r_shift, r_rx_sync};
            w_par_err_next = ^{r_shift, r_rx_sync};
            w_state_next   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_sample_cnt_next = r_sample_cnt + 4'd1;
          if (r_sample_cnt == 4'd15) begin
            if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
              w_wr_pend_next = !r_par_bad;
`else
              w_wr_pend_next = 1'b1;
`endif
              w_state_next = S_IDLE;
            end else begin
              w_frame_err_next = 1'b1;
              w_state_next     = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (r_rx_sync) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A read frees a slot in the same cycle, so a write into a full FIFO with rd_en is not an overflow.
  assign w_do_rd      = bus.rd_en && !r_empty;
  assign w_do_wr      = r_wr_pend && (!r_full || w_do_rd);
  assign w_count_next = r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);

  always_ff @(posedge clk_in) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_data_out <= 8'h00;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (r_wr_pend && r_full && !w_do_rd) r_ovf <= 1'b1;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.empty          = r_empty;
  assign bus.full           = r_full;
  assign bus.data_count     = r_count;
  assign bus.frame_error    = r_frame_err;
  assign bus.overflow_error = r_ovf;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error   = r_par_err;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames against a queue model.
// Runs at a reduced clock so one bit spans 64 clocks; honours UART_RX_PARITY_EN.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 8000000;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = 5;
  localparam int BIT_CLKS = 16 * (CLK_FREQ / (BAUD * 16));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fe_cnt = 0;
  int   pe_cnt = 0;

  logic [7:0] model_q[$];
  logic [7:0] model_dout = 8'h00;
  bit         model_ovf = 1'b0;

  uart_rx_fifo_if #(.CNT_W(CNT_W)) bus();

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_error) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_error) pe_cnt++;
`endif
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx_serial_data = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Good frames enter the model queue, or set the sticky overflow when it is full.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit track);
    bit good;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
    good = stop_ok && par_ok;
`else
    good = stop_ok;
`endif
    drive_bit(stop_ok);
    bus.rx_serial_data = 1'b1;
    repeat (16) @(negedge clk);
    if (track && good) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else model_ovf = 1'b1;
    end
    $display("frame byte=0x%02h stop_ok=%0d par_ok=%0d stored_model=%0d", b, stop_ok, par_ok, model_q.size());
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (model_q.size() > 0) model_dout = model_q.pop_front();
    check_val(tag, bus.data_out, model_dout);
    $display("read %s data_out=0x%02h", tag, bus.data_out);
  endtask

  task automatic check_status(input string tag);
    check_val({tag, ".count"}, bus.data_count, model_q.size());
    check_val({tag, ".empty"}, bus.empty, model_q.size() == 0);
    check_val({tag, ".full"},  bus.full,  model_q.size() == DEPTH);
    check_val({tag, ".ovf"},   bus.overflow_error, model_ovf);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_dout = 8'h00;
    model_ovf  = 1'b0;
  endtask

  initial begin
    int         fe0;
    int         pe0;
    logic [7:0] b;
    bit         stop_ok;
    bit         par_ok;

    bus.rx_serial_data = 1'b1;
    bus.rd_en          = 1'b0;
    repeat (4) @(negedge clk);
    check_val("reset.data_out", bus.data_out, 8'h00);
    check_val("reset.fe", bus.frame_error, 1'b0);
    check_status("reset");
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Single byte through the FIFO.
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    check_status("t1.after_rx");
    do_read("t1.data");
    check_status("t1.after_rd");

    // Short low glitch on the line is not a start bit.
    fe0 = fe_cnt;
    bus.rx_serial_data = 1'b0;
    repeat (16) @(negedge clk);
    bus.rx_serial_data = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_val("t2.fe", fe_cnt - fe0, 0);
    check_status("t2");

    // Stop bit low: one frame_error pulse, byte dropped, next byte stored.
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check_val("t3.fe", fe_cnt - fe0, 1);
    check_status("t3");
    do_read("t3.data");

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, 1'b1);
      if (i >= 15) check_status($sformatf("t4.byte%0d", i + 1));
    end
    for (int i = 0; i < 16; i++) do_read($sformatf("t4.rd%0d", i));
    check_status("t4.drained");
    do_read("t4.empty_hold");
    check_status("t4.empty_hold");

    // Reset in the middle of data bit 3 abandons the frame.
    fe0 = fe_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      begin
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("t5.reset.data_out", bus.data_out, 8'h00);
        check_status("t5.reset");
      end
    join
    check_val("t5.fe", fe_cnt - fe0, 0);
    check_status("t5.after_ff");
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    do_read("t5.data");
    check_status("t5.end");

`ifdef UART_RX_PARITY_EN
    // Wrong parity drops the byte; correct parity stores it.
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check_val("t6.pe", pe_cnt - pe0, 1);
    check_status("t6");
    do_read("t6.data");
`endif

    for (int k = 0; k < 14; k++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 4) != 0);
`endif
      fe0 = fe_cnt;
      pe0 = pe_cnt;
      send_frame(b, stop_ok, par_ok, 1'b1);
      check_val($sformatf("rnd%0d.fe", k), fe_cnt - fe0, !stop_ok);
`ifdef UART_RX_PARITY_EN
      check_val($sformatf("rnd%0d.pe", k), pe_cnt - pe0, !par_ok);
`endif
      check_status($sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 2)) do_read($sformatf("rnd%0d.rd", k));
    end
    while (model_q.size() > 0) do_read("drain");
    check_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side UART with an integrated byte buffer, sitting between the external serial RX pin and fabric logic. It is the receive-direction counterpart of the TX path, where a FIFO feeds uart_tx.
- Deserialises 8N1 frames using 16x oversampling.
- Discards malformed frames.
- Pushes good bytes into an internal synchronous FIFO that a consumer drains with a standard rd_en / data_out read port.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
FIFO_DEPTH, 16, byte entries; power of two, 4..1024
CNT_W, 5, width of data_count; must equal log2(FIFO_DEPTH)+1

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_serial_data  input  1  asynchronous serial line, idle high
rd_en  input  1  pop one byte from the FIFO
data_out  output  8  popped byte, valid the cycle after an accepted rd_en
empty  output  1  FIFO holds zero bytes
full  output  1  FIFO holds FIFO_DEPTH bytes
data_count  output  CNT_W  current FIFO occupancy
frame_error  output  1  one-cycle pulse: stop bit sampled low
overflow_error  output  1  sticky: a good byte was dropped because the FIFO was full

Behaviour:
Clock and reset:
- One clock (clk_in); reset is synchronous and active-high (rst).
- Reset values: data_out=0x00, empty=1, full=0, data_count=0, frame_error=0, overflow_error=0.
- Reset also clears the FSM to IDLE, the pointers, and the tick/bit counters.
- rst mid-frame abandons the partial byte; nothing is written.

Input sampling:
- rx_serial_data passes through a 2-FF synchroniser; both flops reset to 1.
- Oversample tick: divider DIV = CLK_FREQ/(BAUD*16), integer truncated (27 at defaults).
- Tick counter counts 0..DIV-1; tick pulses for one clock at DIV-1.
- The counter runs freely.

FSM (transitions on tick only, except the IDLE start detect):
- IDLE: synced line == 0 -> START, sample counter cleared.
- START: at sample 7, line still 0 -> DATA with sample counter cleared. Line 1 (glitch) -> IDLE, nothing reported.
- DATA: sample at count 15 of each bit window, LSB first, into a shift register. After bit 7 -> STOP.
- STOP: sample at count 15.
  - Line 1 -> attempt FIFO write -> IDLE.
  - Line 0 -> frame_error pulses for exactly one clock, byte discarded -> BREAK.
- BREAK: wait until the synced line == 1, then -> IDLE. A held-low line does not produce repeated frames.

Latency:
- The FIFO write happens on the clock after the STOP sample.
- empty deasserts and data_count increments on the following edge.

FIFO:
- Circular buffer with pointers of log2(FIFO_DEPTH) bits; the pointers wrap naturally.
- Read: rd_en with empty=0 pops; data_out is registered and updates next cycle.
- rd_en while empty is ignored: data_out holds and the count is unchanged.
- Write while full and no simultaneous read: byte dropped, overflow_error set. overflow_error stays set until rst.
- Simultaneous write and read while full: both succeed; count stays FIFO_DEPTH and overflow_error does not set.
- Simultaneous write and read while empty: the read is ignored, the write succeeds, count goes to 1.
- full = (data_count == FIFO_DEPTH); empty = (data_count == 0). Both are registered alongside data_count.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - Frame is 8E1.
  - A PARITY state follows DATA and samples one bit.
  - Adds output parity_error, 1 bit, a one-cycle pulse when the XOR of the 8 data bits and the parity bit equals 1.
  - A failing byte is discarded, then the FSM proceeds through STOP normally.
  - If the stop bit is also low, both error pulses fire, on their respective cycles.
- Undefined: 8N1 only; no parity_error port; no PARITY state.

Test Plan:
1. Defaults; send 0x55 at 115200 baud, then rd_en one cycle after empty falls -> data_count 0->1->0, data_out=0x55 the cycle after rd_en, empty=1 again.
2. Drive the line low for 4 oversample ticks, then high -> no write, data_count stays 0, frame_error stays 0.
3. Send 0xA5 with the stop bit forced low, release the line, then send 0x3C.
   - Required: a single frame_error pulse, data_count=1, read returns 0x3C.
4. FIFO_DEPTH=16; send 0x00..0x10 (17 bytes) with no reads.
   - Required: full=1 after byte 16, overflow_error=1 after byte 17, data_count=16.
   - 16 reads return 0x00..0x0F in order, then empty=1; overflow_error remains 1.
5. Assert rst for one cycle during data bit 3 of 0xFF, then send 0x81.
   - Required: all outputs at reset values after rst, a single read returns 0x81, data_count=0 afterwards.
6. UART_RX_PARITY_EN defined; send 0x07 with parity bit 0 (wrong, even parity requires 1), then 0x07 with parity 1.
   - Required: one parity_error pulse, only the second byte is stored, read returns 0x07.
